ps2_frame_rx: RTL

PS/2 device-to-host frame receiver. It sits directly upstream of the scan-code-to-ASCII keyboard decoder. The block debounces PS2C/PS2D in the clk25 domain and deserialises 11-bit frames. It checks start, parity and stop bits, folds E0/F0 prefixes into flags, and delivers one qualified scan-code event per key make/break with a single-cycle valid strobe. Line errors are reported as error pulses, not as bogus codes.

---
 rtl/ps2_frame_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and filters PS2C/PS2D, deserialises
// 11-bit frames, folds E0/F0 prefixes into flags and emits one strobe per event.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    // Registered strobe lands TIMEOUT_CYCLES-1 cycles after the fall cycle.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 3);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] c_sh_q, d_sh_q;
    logic                  c_f_q, c_f_d, d_f_q, d_f_d, c_fp_q;
    logic                  fall, bit_in;

    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic          ext_pend_q, brk_pend_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    code_q;
    logic          brk_q, ext_q, valid_q, perr_q, ferr_q;

    always_comb begin
        c_f_d = c_f_q;
        d_f_d = d_f_q;
        if (&c_sh_q)       c_f_d = 1'b1;
        else if (~|c_sh_q) c_f_d = 1'b0;
        if (&d_sh_q)       d_f_d = 1'b1;
        else if (~|d_sh_q) d_f_d = 1'b0;
    end

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            c_sh_q   <= '1;
            d_sh_q   <= '1;
            c_f_q    <= 1'b1;
            d_f_q    <= 1'b1;
            c_fp_q   <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], PS2C};
            d_sync_q <= {d_sync_q[0], PS2D};
            c_sh_q   <= {c_sh_q[FILTER_LEN-2:0], c_sync_q[1]};
            d_sh_q   <= {d_sh_q[FILTER_LEN-2:0], d_sync_q[1]};
            c_f_q    <= c_f_d;
            d_f_q    <= d_f_d;
            c_fp_q   <= c_f_q;
        end
    end

    assign fall   = c_fp_q & ~c_f_q;
    assign bit_in = d_f_q;

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            tmo_q      <= '0;
            code_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;

            if (state_q == IDLE || fall) tmo_q <= '0;
            else                         tmo_q <= tmo_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (fall && !bit_in) begin
                        state_q  <= DATA;
                        bitcnt_q <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg_q  <= {bit_in, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par_q   <= bit_in;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state_q <= IDLE;
                        if (!bit_in) begin
                            ferr_q     <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end else if (~^{shreg_q, par_q}) begin
                            perr_q     <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end else if (shreg_q == 8'hE0) begin
                            ext_pend_q <= 1'b1;
                        end else if (shreg_q == 8'hF0) begin
                            brk_pend_q <= 1'b1;
                        end else begin
                            code_q     <= shreg_q;
                            brk_q      <= brk_pend_q;
                            ext_q      <= ext_pend_q;
                            valid_q    <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Abandon a stalled partial frame; a fall in this cycle takes precedence.
            if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
                state_q    <= IDLE;
                ferr_q     <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign is_break   = brk_q;
    assign is_ext     = ext_q;
    assign err_parity = perr_q;
    assign err_frame  = ferr_q;

endmodule
